axis_frame_packer: RTL
======================

AXIS_FRAME_PACKER -- requirements
Module: axis_frame_packer

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 64: input samples per frame; even, 2..1024.
REQ-002 SHALL have parameter FIFO_DEPTH, default 64: FIFO entries; power of two, minimum 4.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port i_clk, input, 1 bit: sole clock, rising edge.
REQ-005 SHALL have port i_rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port s_axis_valid, input, 1 bit: sample present; upstream has no backpressure.
REQ-007 SHALL have port s_axis_data, input, 32 bits: signed sample.
REQ-008 SHALL have port m_axis_tvalid, output, 1 bit: output beat valid.
REQ-009 SHALL have port m_axis_tready, input, 1 bit: downstream accept.
REQ-010 SHALL have port m_axis_tdata, output, 32 bits: output beat.
REQ-011 SHALL have port m_axis_tlast, output, 1 bit: final beat of a frame.
REQ-012 SHALL have port o_overflow, output, 1 bit: sticky drop flag.
REQ-013 SHALL have port o_frame_cnt, output, 16 bits: count of completed output frames.

Function
REQ-014 SHALL count every s_axis_valid cycle, dropped or not, in a sample index 0..FRAME_LEN-1, wrapping to 0 after FRAME_LEN-1; index FRAME_LEN-1 is the last sample.
REQ-015 SHALL store each FIFO entry as 32 data bits plus a last flag, set when the entry contains the last sample.
REQ-016 SHALL accept a FIFO write when not full, or when full and a read handshake (tvalid && tready) occurs in the same cycle.
REQ-017 SHALL, on a rejected write, discard the entry, set o_overflow until reset, and still advance the sample index.
REQ-018 SHALL, if a rejected entry carries the last flag, not emit tlast for that frame and not increment o_frame_cnt for it.
REQ-019 SHALL present the FIFO head first-word-fall-through: m_axis_tvalid = FIFO not empty; an entry written at edge N is visible from cycle N+1.
REQ-020 SHALL hold m_axis_tdata and m_axis_tlast stable while m_axis_tvalid && !m_axis_tready.
REQ-021 SHALL pop exactly one entry per cycle with m_axis_tvalid && m_axis_tready.
REQ-022 SHALL increment o_frame_cnt on each handshake with m_axis_tlast=1, wrapping 16'hFFFF to 0.
REQ-023 SHALL drive m_axis_tdata to 0 when m_axis_tvalid=0.

Reset
REQ-024 SHALL, when i_rst=1 at a clock edge, clear FIFO pointers and count, sample index, pack register, o_overflow and o_frame_cnt.
REQ-025 SHALL, while in reset, drive m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, o_overflow=0 and o_frame_cnt=0.
REQ-026 SHALL discard data in flight on reset mid-frame; after release, the next sample is index 0.

Configuration
REQ-027 SHALL provide compile-time macro AXIS_FRAME_PACK16_EN.
REQ-028 SHALL, with AXIS_FRAME_PACK16_EN defined, saturate each sample to signed 16 bits [-32768, 32767] and pack pairs: even index to bits 15:0, odd index to bits 31:16.
REQ-029 SHALL, with AXIS_FRAME_PACK16_EN defined, write the packed word on the odd sample with that sample's last flag, giving FRAME_LEN/2 beats per frame.
REQ-030 SHALL, without AXIS_FRAME_PACK16_EN, write each sample unchanged as one entry, giving FRAME_LEN beats per frame, and omit the pack register.

Structure
REQ-031 SHALL place the data width (32), packed half width (16), default FRAME_LEN and the 16-bit saturation function in shared package axis_frame_pkg.
REQ-032 SHALL implement storage in sub-module axis_sync_fifo, parameterised by width (33) and depth, with FWFT read, full, empty and count outputs.

Verification
REQ-033 SHALL cover: 64 consecutive samples 0..63, tready=1, no pack -> 64 beats 0..63, tlast only on 63, o_frame_cnt=1.
REQ-034 SHALL cover: pack on, samples 100, -5, 40000, -40000 (FRAME_LEN=4) -> beats 32'hFFFB0064 then 32'h80007FFF with tlast, o_frame_cnt=1.
REQ-035 SHALL cover: tready=0 for 70 valid samples, FIFO_DEPTH=64, no pack -> 64 entries held, o_overflow=1; after tready=1, words 0..63 out, tlast on word 63.
REQ-036 SHALL cover: tready toggling every cycle -> tdata and tlast stable during stalls, no loss or duplication across 3 frames, o_frame_cnt=3.
REQ-037 SHALL cover: i_rst pulsed after sample 20 of a frame, then 64 new samples -> no stale beats; one frame with tlast on the 64th new sample.
REQ-038 SHALL cover: FIFO full with simultaneous write and read handshake -> write accepted, o_overflow stays 0.

Source files
------------

// File: rtl/axis_frame_pkg.sv
// Shared widths, FIFO entry layout and 16-bit saturation for the frame packer.
// Optional pairwise packing in the top is enabled by AXIS_FRAME_PACK16_EN.
package axis_frame_pkg;

   localparam int DATA_W            = 32;
   localparam int HALF_W            = 16;
   localparam int DEFAULT_FRAME_LEN = 64;

   typedef struct packed {
      logic              last;
      logic [DATA_W-1:0] dat;
   } beat_t;

   localparam int BEAT_W = $bits(beat_t);

   function automatic logic [HALF_W-1:0] sat16(input logic signed [DATA_W-1:0] x);
      logic [HALF_W-1:0] r;
      if (x > 32'sd32767) begin
         r = 16'h7FFF;
      end else if (x < -32'sd32768) begin
         r = 16'h8000;
      end else begin
         r = x[HALF_W-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; a write at edge N is readable from cycle N+1.
// A write into a full FIFO is taken only when a pop happens in the same cycle.
module axis_sync_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 64
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     wr_vld,
   input  logic [WIDTH-1:0]         wr_dat,
   input  logic                     rd_rdy,
   output logic [WIDTH-1:0]         rd_dat,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             wr_push;
   logic             rd_pop;

   assign full   = (count_q == CW'(DEPTH));
   assign empty  = (count_q == '0);
   assign count  = count_q;
   assign rd_dat = mem_q[rd_ptr_q];

   // Full implies non-empty, so a ready downstream frees the slot being written.
   assign rd_pop  = rd_rdy && !empty;
   assign wr_push = wr_vld && (!full || rd_pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_push) begin
         mem_d[wr_ptr_q] = wr_dat;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (rd_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({wr_push, rd_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge i_clk) begin
      mem_q <= mem_d;
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/axis_frame_packer.sv
// Frames a backpressure-free sample stream into AXI-Stream beats through a FWFT FIFO; one-cycle latency.
// No upstream backpressure: writes that find the FIFO full are dropped and flagged. AXIS_FRAME_PACK16_EN packs sample pairs.
module axis_frame_packer
   import axis_frame_pkg::*;
#(
   parameter int FRAME_LEN  = DEFAULT_FRAME_LEN,
   parameter int FIFO_DEPTH = 64
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              s_axis_valid,
   input  logic [DATA_W-1:0] s_axis_data,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tlast,
   output logic              o_overflow,
   output logic [15:0]       o_frame_cnt
);

   localparam int IDX_W = $clog2(FRAME_LEN);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

   logic [IDX_W-1:0] idx_q, idx_d;
   logic             ovf_q, ovf_d;
   logic [15:0]      frame_cnt_q, frame_cnt_d;
   logic             is_last;
   logic             wr_vld;
   beat_t            wr_beat;
   beat_t            rd_beat;
   logic             fifo_full;
   logic             fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;
   logic             rd_rdy;
   logic             out_hs;

   assign is_last = (idx_q == LAST_IDX);

`ifdef AXIS_FRAME_PACK16_EN
   logic [HALF_W-1:0] pack_q, pack_d;

   // Even samples park in the pack register; the odd partner completes the word.
   always_comb begin
      pack_d          = pack_q;
      wr_vld          = s_axis_valid && idx_q[0];
      wr_beat.last    = is_last;
      wr_beat.dat     = {sat16($signed(s_axis_data)), pack_q};
      if (s_axis_valid && !idx_q[0]) begin
         pack_d = sat16($signed(s_axis_data));
      end
   end
`else
   always_comb begin
      wr_vld       = s_axis_valid;
      wr_beat.last = is_last;
      wr_beat.dat  = s_axis_data;
   end
`endif

   axis_sync_fifo #(
      .WIDTH (BEAT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .wr_vld (wr_vld),
      .wr_dat (wr_beat),
      .rd_rdy (rd_rdy),
      .rd_dat (rd_beat),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .count  (unused_fifo_count)
   );

   assign rd_rdy = m_axis_tready && !i_rst;
   assign out_hs = !fifo_empty && rd_rdy;

   always_comb begin
      idx_d       = idx_q;
      ovf_d       = ovf_q;
      frame_cnt_d = frame_cnt_q;
      if (s_axis_valid) begin
         idx_d = is_last ? '0 : idx_q + IDX_W'(1);
      end
      // A dropped last-flagged entry simply never reaches the output, so its frame is not counted.
      if (wr_vld && fifo_full && !out_hs) begin
         ovf_d = 1'b1;
      end
      if (out_hs && rd_beat.last) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         idx_q       <= '0;
         ovf_q       <= 1'b0;
         frame_cnt_q <= '0;
`ifdef AXIS_FRAME_PACK16_EN
         pack_q      <= '0;
`endif
      end else begin
         idx_q       <= idx_d;
         ovf_q       <= ovf_d;
         frame_cnt_q <= frame_cnt_d;
`ifdef AXIS_FRAME_PACK16_EN
         pack_q      <= pack_d;
`endif
      end
   end

   assign m_axis_tvalid = !fifo_empty && !i_rst;
   assign m_axis_tdata  = m_axis_tvalid ? rd_beat.dat : '0;
   assign m_axis_tlast  = m_axis_tvalid && rd_beat.last;
   assign o_overflow    = ovf_q && !i_rst;
   assign o_frame_cnt   = i_rst ? 16'd0 : frame_cnt_q;

endmodule
